// File: rtl/idu_queued_if.sv
// Decode-stage bus bundle: IFU request side, EXU response side, writeback port and flush.
// The slave modport is the decode stage; the master modport drives it.
interface idu_queued_if #(
    parameter int XLEN = 32
);
    localparam int PAYLOAD_W = 4*XLEN + 37;

    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_pc;
    logic [31:0]          in_inst;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 wb_wen;
    logic [4:0]           wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 flush;

    modport master (
        output in_valid, in_pc, in_inst, out_ready, wb_wen, wb_addr, wb_data, flush,
        input  in_ready, out_valid, out_payload
    );
    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, wb_wen, wb_addr, wb_data, flush,
        output in_ready, out_valid, out_payload
    );
endinterface

// File: rtl/idu_queued.sv
// Queued RV32I decode stage: regfile read with wb bypass, branch resolve, DEPTH-entry output FIFO.
// Define IDU_SCOREBOARD_EN to add the RAW/WAW busy-vector stall against in-flight writebacks.
module idu_queued #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input logic         clk,
    input logic         rst,
    idu_queued_if.slave io
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        logic [11:0]     csr_addr;
        logic [1:0]      csr_op;
        logic            pc_rs1_sel;
        logic            rs2_imm_sel;
        logic            reg_wen;
        logic            mem_en;
        logic            mem_wen;
        logic            is_jump;
        logic            br_taken;
        logic            is_ecall;
        logic            is_ebreak;
        logic            is_mret;
        logic            illegal;
    } payload_t;

    logic [31:0][XLEN-1:0] rf_q;
    payload_t              mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;

    logic [31:0]     inst;
    logic [2:0]      f3;
    logic [4:0]      rs1a, rs2a;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            use_rs1, use_rs2, br_cmp, stall, push, pop;
    payload_t        dec;

    assign inst = io.in_inst;
    assign f3   = inst[14:12];
    assign rs1a = inst[19:15];
    // ECALL passes its argument register x15 through the rs2 read port.
    assign rs2a = (inst == 32'h0000_0073) ? 5'd15 : inst[24:20];

    assign rs1_val = (rs1a == 5'd0) ? '0 :
                     (io.wb_wen && io.wb_addr == rs1a) ? io.wb_data : rf_q[rs1a];
    assign rs2_val = (rs2a == 5'd0) ? '0 :
                     (io.wb_wen && io.wb_addr == rs2a) ? io.wb_data : rf_q[rs2a];

    always_comb begin
        unique case (f3)
            3'b000:  br_cmp = rs1_val == rs2_val;
            3'b001:  br_cmp = rs1_val != rs2_val;
            3'b100:  br_cmp = $signed(rs1_val) <  $signed(rs2_val);
            3'b101:  br_cmp = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  br_cmp = rs1_val <  rs2_val;
            3'b111:  br_cmp = rs1_val >= rs2_val;
            default: br_cmp = 1'b0;
        endcase
    end

    always_comb begin
        dec        = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec.pc     = io.in_pc;
        dec.funct3 = f3;
        unique case (inst[6:0])
            OP_LUI: begin
                dec.imm = {inst[31:12], 12'b0};
                dec.rs2_imm_sel = 1'b1; dec.reg_wen = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm = {inst[31:12], 12'b0};
                dec.pc_rs1_sel = 1'b1; dec.rs2_imm_sel = 1'b1; dec.reg_wen = 1'b1;
            end
            OP_JAL: begin
                dec.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                dec.pc_rs1_sel = 1'b1; dec.rs2_imm_sel = 1'b1; dec.reg_wen = 1'b1;
                dec.is_jump = 1'b1; dec.br_taken = 1'b1;
            end
            OP_JALR: begin
                dec.imm = {{20{inst[31]}}, inst[31:20]};
                use_rs1 = 1'b1; dec.rs2_imm_sel = 1'b1; dec.reg_wen = 1'b1;
                dec.is_jump = 1'b1; dec.br_taken = 1'b1;
            end
            OP_BRANCH: begin
                dec.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.br_taken = br_cmp;
            end
            OP_LOAD: begin
                dec.imm = {{20{inst[31]}}, inst[31:20]};
                use_rs1 = 1'b1; dec.rs2_imm_sel = 1'b1; dec.reg_wen = 1'b1; dec.mem_en = 1'b1;
            end
            OP_STORE: begin
                dec.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.rs2_imm_sel = 1'b1;
                dec.mem_en = 1'b1; dec.mem_wen = 1'b1;
            end
            OP_IMM: begin
                dec.imm = {{20{inst[31]}}, inst[31:20]};
                use_rs1 = 1'b1; dec.rs2_imm_sel = 1'b1; dec.reg_wen = 1'b1;
                dec.alu_op = {(f3 == 3'b101) && inst[30], f3};
            end
            OP_OP: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.reg_wen = 1'b1;
                dec.alu_op = {inst[30], f3};
            end
            OP_SYSTEM: begin
                if (f3 == 3'b000) begin
                    unique case (inst)
                        32'h0000_0073: begin dec.is_ecall = 1'b1; use_rs2 = 1'b1; end
                        32'h0010_0073: dec.is_ebreak = 1'b1;
                        32'h3020_0073: dec.is_mret   = 1'b1;
                        default:       dec.illegal   = 1'b1;
                    endcase
                end else if (f3 == 3'b100) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.reg_wen  = 1'b1;
                    dec.csr_addr = inst[31:20];
                    dec.csr_op   = f3[1:0];
                    use_rs1      = !f3[2];
                    // Immediate CSR forms carry zimm in the rs1 operand slot.
                    if (f3[2]) dec.rs1_data = {{(XLEN-5){1'b0}}, inst[19:15]};
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (use_rs1) dec.rs1_data = rs1_val;
        if (use_rs2) dec.rs2_data = rs2_val;
        if (dec.reg_wen) dec.rd = inst[11:7];
    end

`ifdef IDU_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    assign stall = (use_rs1 && busy_q[rs1a] && !(io.wb_wen && io.wb_addr == rs1a)) ||
                   (use_rs2 && busy_q[rs2a] && !(io.wb_wen && io.wb_addr == rs2a)) ||
                   (dec.reg_wen && dec.rd != 5'd0 && busy_q[dec.rd]);

    always_comb begin
        busy_d = busy_q;
        if (io.wb_wen) busy_d[io.wb_addr] = 1'b0;
        if (io.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < count_q && mem_q[rd_ptr_q + PW'(i)].reg_wen)
                    busy_d[mem_q[rd_ptr_q + PW'(i)].rd] = 1'b0;
            end
        end
        // Set after clear so a same-register wb and accept leaves it busy.
        if (push && dec.reg_wen && dec.rd != 5'd0) busy_d[dec.rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end
`else
    assign stall = 1'b0;
`endif

    assign io.in_ready    = !rst && (count_q < CW'(DEPTH)) && !io.flush && !stall;
    assign io.out_valid   = count_q != '0;
    assign io.out_payload = io.out_valid ? mem_q[rd_ptr_q] : '0;

    assign push = io.in_valid && io.in_ready;
    assign pop  = io.out_valid && io.out_ready && !io.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (io.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                rf_q <= '0;
        else if (io.wb_wen && io.wb_addr != '0) rf_q[io.wb_addr] <= io.wb_data;
    end
endmodule

// File: doc/idu_queued.md
# idu_queued

Parametrised decode stage. It takes fetched instructions from the IFU and decodes them against an internal 32×32 register file, resolving branch conditions along the way. Decoded payloads go into a DEPTH-entry output FIFO that drains to the EXU over a valid/ready handshake. It adds three things a single-slot decode stage lacks: back-to-back acceptance, a flush input, and an optional RAW/WAW scoreboard against writebacks still in flight.

## Interface
- DEPTH, 2: output FIFO entries; power of two, ≥2.
- XLEN, 32: data width of register file, PC and immediates; only 32 is legal.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  IFU holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  XLEN  PC of the instruction.
- in_inst  in  32  instruction word.
- out_valid  out  1  head FIFO entry valid.
- out_ready  in  1  EXU accepts the head entry.
- out_payload  out  PAYLOAD_W  head entry, fields packed MSB→LSB:
  - pc, rs1_data, rs2_data, imm (XLEN each)
  - rd (5), funct3 (3), alu_op (4), csr_addr (12), csr_op (2)
  - flags, 1 bit each: pc_rs1_sel, rs2_imm_sel, reg_wen, mem_en, mem_wen, is_jump, br_taken, is_ecall, is_ebreak, is_mret, illegal
- wb_wen  in  1  writeback strobe.
- wb_addr  in  5  writeback register.
- wb_data  in  XLEN  writeback data.
- flush  in  1  discard all queued entries.

## Operation
- Accept on `in_valid && in_ready`.
- `in_ready = !rst && count<DEPTH && !flush && !stall`.
- The decoded payload is written to the FIFO tail on the accept edge. Decode covers:
  - RV32I: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - SYSTEM: ECALL, EBREAK, MRET.
  - CSR: CSRRW/S/C and their immediate forms. Immediate forms place zimm in rs1_data; csr_op is 1=write, 2=set, 3=clear, 0=none.
- Any other opcode sets `illegal=1` with `reg_wen=0` and `mem_en=0`.
- Branch: `br_taken` comes from comparing rs1/rs2; BLTU and BGEU compare unsigned. JAL and JALR set `is_jump=1`, `reg_wen=1`, `br_taken=1`.
- ECALL (0x00000073) reads x15 on the rs2 port.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - A write on wb in the same cycle as a decode read bypasses to the read data.
  - All registers reset to 0.
- FIFO:
  - Pop on `out_valid && out_ready`.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `out_valid = count!=0`.
- Flush:
  - count ← 0 and pointers ← 0 on the next edge; any accept or pop in that cycle is void.
  - The scoreboard clears the busy bit of the rd of every queued entry with reg_wen.
  - wb still applies.
- Reset (asynchronous): count=0, pointers=0, busy=0, regfile=0.
  - Outputs during reset: out_valid=0, in_ready=0, out_payload=0.

## Timing
- Latency: an instruction accepted at edge N appears at the head at N+1 if the FIFO was empty.
- Throughput: one instruction per cycle while not full or stalled. in_ready does not look at out_ready, so a full FIFO blocks input even when a pop occurs in the same cycle.
- out_payload changes only after a pop or a push-into-empty. It is stable while `out_valid && !out_ready`.
- Scoreboard:
  - busy[rd] is set on accept of an instruction with reg_wen and rd≠0.
  - busy[wb_addr] is cleared on wb_wen.
  - If both hit the same register in one cycle, set wins.
- Stall condition: any source is busy and not being cleared this cycle, or rd is busy (WAW). Sources per class:
  - rs1: JALR, BRANCH, LOAD, STORE, OP-IMM, OP, CSR register forms.
  - rs2: BRANCH, STORE, OP.
  - x15: ECALL.

## Configuration
- IDU_SCOREBOARD_EN defined: busy vector and stall logic are present, as described above.
- Undefined: no busy state. stall=0 and `in_ready = !rst && count<DEPTH && !flush`; hazards are the downstream stage's responsibility.

## Test plan
- Reset mid-stream with 2 entries queued → out_valid=0 immediately; after release, in_ready=1 and count=0.
- DEPTH=2, out_ready=0, push 3 instructions → third is held with in_ready=0; payloads pop in order once out_ready=1.
- `addi x5,x0,7` followed by `add x6,x5,x5` (scoreboard on) → second stalls until wb_wen with wb_addr=5; with wb_data=7 in the same cycle, it issues with rs1_data=rs2_data=7.
- Flush with 2 queued entries writing x5 and x6 → out_valid=0 next cycle; busy[5]=busy[6]=0; the next `add x7,x5,x6` is accepted without stall.
- `bltu x1,x2` with x1=0xFFFFFFFF, x2=1 → br_taken=0; `blt` on the same values → br_taken=1.
- ECALL with x15=0x1234 → is_ecall=1, rs2_data=0x1234. `csrrwi x3,mtvec,5` → csr_op=1, rs1_data=5, csr_addr=0x305, reg_wen=1.
